// File: rtl/tt_ctrl_sync_if.sv
// Control-pad and spine-select bundle for tt_ctrl_sync.
// The master drives the pad-level controls and the slave drives the selection outputs.
interface tt_ctrl_sync_if #(
    parameter int N_SIDE = 2,
    parameter int SEL_W  = 10
);
    localparam int SW = $clog2(N_SIDE);

    logic                ctrl_sel_rst_n;
    logic                ctrl_sel_inc;
    logic                ctrl_sel_load;
    logic                ctrl_sel_data;
    logic                ctrl_ena;
    logic [SEL_W-1:0]    sel_addr;
    logic [SEL_W-SW-1:0] spine_sel;
    logic [SW-1:0]       side_sel;
    logic [N_SIDE-1:0]   side_ena;
    logic                busy;

    modport master (
        output ctrl_sel_rst_n, ctrl_sel_inc, ctrl_sel_load, ctrl_sel_data, ctrl_ena,
        input  sel_addr, spine_sel, side_sel, side_ena, busy
    );

    modport slave (
        input  ctrl_sel_rst_n, ctrl_sel_inc, ctrl_sel_load, ctrl_sel_data, ctrl_ena,
        output sel_addr, spine_sel, side_sel, side_ena, busy
    );
endinterface

// File: rtl/tt_ctrl_sync.sv
// Clocked spine/side selection with resynchronised pads, serial address load
// and a break-before-make guard interval on every selection change.
module tt_ctrl_sync #(
    parameter int N_SIDE   = 2,
    parameter int SEL_W    = 10,
    parameter int SIDE_LSB = 5,
    parameter int GUARD    = 4
) (
    input  logic          clk,
    input  logic          rst,
    tt_ctrl_sync_if.slave bus
);
    localparam int SW = $clog2(N_SIDE);
    localparam int GW = $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD - 1);

    // state  | meaning
    // IDLE   | design disabled, all spines off
    // GUARD  | break-before-make interval, all spines off
    // ACTIVE | exactly one spine enabled on side_sel
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    logic [4:0]        w_pad;
    logic [4:0]        r_meta;
    logic [4:0]        r_sync;
    logic              r_inc_q;
    logic              r_ena_q;
    logic              w_sel_rst_n_s;
    logic              w_inc_s;
    logic              w_load_s;
    logic              w_data_s;
    logic              w_ena_s;
    logic              w_inc_rise;
    logic              w_chg;
    logic [SEL_W-1:0]  r_addr;
    logic [SEL_W-1:0]  w_addr_nxt;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_guard_cnt;
    logic [GW-1:0]     w_guard_cnt_nxt;
    logic [N_SIDE-1:0] r_side_ena;
    logic [N_SIDE-1:0] w_side_ena_nxt;
    logic              r_busy;

    assign w_pad = {bus.ctrl_ena, bus.ctrl_sel_data, bus.ctrl_sel_load,
                    bus.ctrl_sel_inc, bus.ctrl_sel_rst_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= '0;
            r_sync  <= '0;
            r_inc_q <= 1'b0;
            r_ena_q <= 1'b0;
        end else begin
            r_meta  <= w_pad;
            r_sync  <= r_meta;
            r_inc_q <= r_sync[1];
            r_ena_q <= r_sync[4];
        end
    end

    assign w_sel_rst_n_s = r_sync[0];
    assign w_inc_s       = r_sync[1];
    assign w_load_s      = r_sync[2];
    assign w_data_s      = r_sync[3];
    assign w_ena_s       = r_sync[4];
    assign w_inc_rise    = w_inc_s & ~r_inc_q;

    always_comb begin
        w_addr_nxt = r_addr;
        if (!w_sel_rst_n_s) begin
            w_addr_nxt = '0;
        end else if (w_inc_rise && w_load_s) begin
            w_addr_nxt = {r_addr[SEL_W-2:0], w_data_s};
        end else if (w_inc_rise) begin
            w_addr_nxt = r_addr + SEL_W'(1);
        end
    end

    // Rewriting the same address is not a selection change.
    assign w_chg = (w_addr_nxt != r_addr) || (r_ena_q && !w_ena_s);

    always_comb begin
        w_state_nxt     = r_state;
        w_guard_cnt_nxt = r_guard_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_ena_s) begin
                    w_state_nxt     = ST_GUARD;
                    w_guard_cnt_nxt = GUARD_LD;
                end
            end
            ST_GUARD: begin
                if (w_chg || !w_ena_s) begin
                    w_guard_cnt_nxt = GUARD_LD;
                    if (!w_ena_s) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_guard_cnt == '0) begin
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_guard_cnt_nxt = r_guard_cnt - GW'(1);
                end
            end
            ST_ACTIVE: begin
                if (!w_ena_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_chg) begin
                    w_state_nxt     = ST_GUARD;
                    w_guard_cnt_nxt = GUARD_LD;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_guard_cnt_nxt = '0;
            end
        endcase
    end

    // Decoding from next state and next address keeps the enable off a stale side.
    always_comb begin
        w_side_ena_nxt = '0;
        if (w_state_nxt == ST_ACTIVE) begin
            w_side_ena_nxt[w_addr_nxt[SIDE_LSB +: SW]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_guard_cnt <= '0;
            r_addr      <= '0;
            r_side_ena  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_guard_cnt <= w_guard_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_side_ena  <= w_side_ena_nxt;
            r_busy      <= (w_state_nxt == ST_GUARD);
        end
    end

    assign bus.sel_addr = r_addr;
    assign bus.side_sel = r_addr[SIDE_LSB +: SW];
    assign bus.side_ena = r_side_ena;
    assign bus.busy     = r_busy;

    for (genvar g = 0; g < SEL_W - SW; g++) begin : g_spine
        assign bus.spine_sel[g] = r_addr[(g < SIDE_LSB) ? g : g + SW];
    end
endmodule

// File: tb/tb_tt_ctrl_sync.sv
// Scoreboard bench for tt_ctrl_sync: expected addresses are queued as pad stimulus
// is driven and popped when the DUT address changes; guard timing is checked inline.
module tb_tt_ctrl_sync;
    localparam int N_SIDE   = 2;
    localparam int SEL_W    = 10;
    localparam int SIDE_LSB = 5;
    localparam int GUARD    = 4;
    localparam int SW       = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_ctrl_sync_if #(.N_SIDE(N_SIDE), .SEL_W(SEL_W)) bus();

    tt_ctrl_sync #(
        .N_SIDE(N_SIDE), .SEL_W(SEL_W), .SIDE_LSB(SIDE_LSB), .GUARD(GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [SEL_W-1:0] sb_q[$];
    logic [SEL_W-1:0] m_addr   = '0;
    logic [SEL_W-1:0] mon_prev = '0;
    logic [SEL_W-1:0] mon_exp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] side_of(input logic [SEL_W-1:0] a);
        return a[SIDE_LSB +: SW];
    endfunction

    function automatic logic [SEL_W-SW-1:0] spine_of(input logic [SEL_W-1:0] a);
        logic [SEL_W-SW-1:0] s;
        int j;
        s = '0;
        j = 0;
        for (int i = 0; i < SEL_W; i++) begin
            if (i < SIDE_LSB || i >= SIDE_LSB + SW) begin
                s[j] = a[i];
                j++;
            end
        end
        return s;
    endfunction

    function automatic logic [N_SIDE-1:0] onehot_of(input logic [SEL_W-1:0] a);
        logic [N_SIDE-1:0] o;
        o = '0;
        o[side_of(a)] = 1'b1;
        return o;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mon_prev = '0;
        end else begin
            check_val("onehot", 32'($countones(bus.side_ena) <= 1), 32'd1);
            if (bus.sel_addr !== mon_prev) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_extra", 32'(bus.sel_addr), 32'(mon_prev));
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_val("sb_addr", 32'(bus.sel_addr), 32'(mon_exp));
                    check_val("sb_side_sel", 32'(bus.side_sel), 32'(side_of(mon_exp)));
                    check_val("sb_spine", 32'(bus.spine_sel), 32'(spine_of(mon_exp)));
                end
                mon_prev = bus.sel_addr;
            end
        end
    end

    task automatic wait_change(input logic [SEL_W-1:0] old);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.sel_addr !== old) return;
        end
        check_val("change_timeout", 32'(bus.sel_addr), 32'(old) ^ 32'd1);
    endtask

    // Called at the negedge right after the change edge.
    task automatic guard_check(input logic [N_SIDE-1:0] exp_ena);
        check_val("guard_e0_ena", 32'(bus.side_ena), 32'd0);
        check_val("guard_e0_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i < GUARD; i++) begin
            @(negedge clk);
            check_val("guard_ena", 32'(bus.side_ena), 32'd0);
            check_val("guard_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check_val("guard_done_ena", 32'(bus.side_ena), 32'(exp_ena));
        check_val("guard_done_busy", 32'(bus.busy), 32'd0);
    endtask

    // Called one cycle after the last change of a fast pulse burst.
    task automatic fast_post(input logic [N_SIDE-1:0] exp_ena);
        check_val("burst_ena", 32'(bus.side_ena), 32'd0);
        check_val("burst_busy", 32'(bus.busy), 32'd1);
        for (int i = 2; i < GUARD; i++) begin
            @(negedge clk);
            check_val("burst_ena", 32'(bus.side_ena), 32'd0);
            check_val("burst_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check_val("burst_done_ena", 32'(bus.side_ena), 32'(exp_ena));
        check_val("burst_done_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_pulse(input logic ld, input logic d, input bit fast);
        logic [SEL_W-1:0] old;
        logic [SEL_W-1:0] nxt;
        old = m_addr;
        if (!bus.ctrl_sel_rst_n) nxt = old;
        else if (ld)             nxt = {old[SEL_W-2:0], d};
        else                     nxt = old + SEL_W'(1);
        bus.ctrl_sel_load = ld;
        bus.ctrl_sel_data = d;
        bus.ctrl_sel_inc  = 1'b1;
        if (nxt != old) sb_q.push_back(nxt);
        m_addr = nxt;
        repeat (2) @(negedge clk);
        bus.ctrl_sel_inc = 1'b0;
        if (fast) begin
            repeat (2) @(negedge clk);
        end else if (nxt != old) begin
            wait_change(old);
            guard_check(onehot_of(nxt));
        end else begin
            repeat (3) @(negedge clk);
            check_val("no_change", 32'(bus.sel_addr), 32'(old));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SEL_W-1:0] pat;
        logic [SEL_W-1:0] old;
        bus.ctrl_sel_rst_n = 1'b1;
        bus.ctrl_sel_inc   = 1'b0;
        bus.ctrl_sel_load  = 1'b0;
        bus.ctrl_sel_data  = 1'b0;
        bus.ctrl_ena       = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_addr", 32'(bus.sel_addr), 32'd0);
        check_val("rst_ena", 32'(bus.side_ena), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // power-up with ena high: GUARD cycles from edge 3, then side 0
        for (int k = 1; k <= GUARD + 3; k++) begin
            @(negedge clk);
            check_val("pwr_ena", 32'(bus.side_ena), (k <= 2 + GUARD) ? 32'd0 : 32'd1);
            check_val("pwr_busy", 32'(bus.busy), (k >= 3 && k <= 2 + GUARD) ? 32'd1 : 32'd0);
        end
        check_val("pwr_addr", 32'(bus.sel_addr), 32'd0);

        for (int i = 0; i < 32; i++) do_pulse(1'b0, 1'b0, 1'b0);
        check_val("inc32_addr", 32'(bus.sel_addr), 32'd32);
        check_val("inc32_side", 32'(bus.side_sel), 32'd1);
        check_val("inc32_spine", 32'(bus.spine_sel), 32'd0);

        for (int i = 0; i < SEL_W; i++) do_pulse(1'b1, 1'b1, 1'b0);
        check_val("ones_addr", 32'(bus.sel_addr), 32'd1023);
        do_pulse(1'b0, 1'b0, 1'b0);
        check_val("wrap_addr", 32'(bus.sel_addr), 32'd0);
        check_val("wrap_side", 32'(bus.side_sel), 32'd0);

        pat = 10'b1000100011;
        for (int i = SEL_W - 1; i >= 0; i--) do_pulse(1'b1, pat[i], 1'b1);
        bus.ctrl_sel_load = 1'b0;
        fast_post(2'b10);
        check_val("load_addr", 32'(bus.sel_addr), 32'h223);
        check_val("load_side", 32'(bus.side_sel), 32'd1);
        check_val("load_spine", 32'(bus.spine_sel), 32'b100000011);

        // second change lands as the first guard is about to expire
        do_pulse(1'b0, 1'b0, 1'b1);
        do_pulse(1'b0, 1'b0, 1'b1);
        fast_post(2'b10);
        check_val("dbl_addr", 32'(bus.sel_addr), 32'h225);

        old = m_addr;
        bus.ctrl_sel_rst_n = 1'b0;
        m_addr = '0;
        sb_q.push_back('0);
        wait_change(old);
        guard_check(2'b01);
        do_pulse(1'b0, 1'b0, 1'b0);
        bus.ctrl_sel_rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("srst_addr", 32'(bus.sel_addr), 32'd0);

        bus.ctrl_ena = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_val("enaoff_ena", 32'(bus.side_ena), (k <= 2) ? 32'd1 : 32'd0);
            check_val("enaoff_busy", 32'(bus.busy), 32'd0);
        end
        bus.ctrl_ena = 1'b1;
        for (int k = 1; k <= GUARD + 3; k++) begin
            @(negedge clk);
            check_val("enaon_ena", 32'(bus.side_ena), (k <= 2 + GUARD) ? 32'd0 : 32'd1);
            check_val("enaon_busy", 32'(bus.busy), (k >= 3 && k <= 2 + GUARD) ? 32'd1 : 32'd0);
        end

        // asynchronous reset while guarding
        bus.ctrl_sel_inc = 1'b1;
        m_addr = 10'd1;
        sb_q.push_back(10'd1);
        repeat (2) @(negedge clk);
        bus.ctrl_sel_inc = 1'b0;
        wait_change('0);
        check_val("midg_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        m_addr = '0;
        #1;
        check_val("arst_addr", 32'(bus.sel_addr), 32'd0);
        check_val("arst_spine", 32'(bus.spine_sel), 32'd0);
        check_val("arst_side", 32'(bus.side_sel), 32'd0);
        check_val("arst_ena", 32'(bus.side_ena), 32'd0);
        check_val("arst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
